// File: rtl/fpu_csr_pkg.sv
// Shared types and constants for the FPU control/status register bank.
// Holds the handshake FSM encoding, CSR bit positions and the index helper.
package fpu_csr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fpu_csr_state_e;

   localparam int CTRL_IE_BIT    = 8;
   localparam int CTRL_START_BIT = 9;

   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_DONE_BIT  = 1;
   localparam int STAT_ERR_BIT   = 2;
   localparam int STAT_TO_BIT    = 3;
   localparam int STAT_FLAGS_LSB = 4;

   localparam int FLAGS_W = 5;
   localparam int FLAG_NX = 0;
   localparam int FLAG_UF = 1;
   localparam int FLAG_OF = 2;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_NV = 4;

   typedef struct packed {
      logic [7:0] ctrl;
      logic [7:0] status;
      logic [7:0] result;
   } csr_idx_t;

   // The control registers sit directly above the operand registers.
   function automatic csr_idx_t csr_idx(input int num_ops);
      csr_idx_t idx;
      idx.ctrl   = 8'(num_ops);
      idx.status = 8'(num_ops + 1);
      idx.result = 8'(num_ops + 2);
      return idx;
   endfunction

endpackage

// File: rtl/fpu_csr_timeout.sv
// Watchdog for the WAIT state: loaded on entry, counts down while active.
// expired_o flags the last permitted WAIT cycle.
module fpu_csr_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic active_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Reload on WAIT entry, otherwise count down to zero while waiting.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = LOAD_VAL;
      end else if (active_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = active_i && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fpu_csr_bank.sv
// Operand/control/status register bank that issues one FPU operation at a
// time over a req/ack handshake and reports completion via STATUS and IRQ.
module fpu_csr_bank
   import fpu_csr_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_OPS    = 2,
   parameter int ADDR_W     = 3,
   parameter int OPSEL_W    = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [ADDR_W-1:0]             ADDR,
   input  logic [DATA_WIDTH-1:0]         WDATA,
   input  logic                          WRITE,
   input  logic                          ENABLE,
   output logic [DATA_WIDTH-1:0]         RDATA,
   output logic [NUM_OPS*DATA_WIDTH-1:0] OP_BUS,
   output logic [OPSEL_W-1:0]            OP_SELECT,
   output logic                          FPU_REQ,
   input  logic                          FPU_ACK,
   input  logic                          FPU_VALID,
   input  logic [DATA_WIDTH-1:0]         FPU_RESULT,
   input  logic [FLAGS_W-1:0]            FPU_FLAGS,
   output logic                          IRQ
);

   localparam csr_idx_t IDX = csr_idx(NUM_OPS);

   fpu_csr_state_e state_q, state_d;

   logic [NUM_OPS*DATA_WIDTH-1:0] op_q, op_d;
   logic [OPSEL_W-1:0]            opsel_q, opsel_d;
   logic                          ie_q, ie_d;
   logic                          done_q, done_d;
   logic                          err_q, err_d;
   logic                          to_q, to_d;
   logic [FLAGS_W-1:0]            flags_q, flags_d;
   logic [DATA_WIDTH-1:0]         result_q, result_d;
   logic [DATA_WIDTH-1:0]         rdata_q, rdata_d, rd_mux_s;
   logic                          req_q, irq_q;

   logic [7:0] addr_ext_s;
   logic       wr_s, rd_s, busy_s;
   logic       hit_op_s, hit_ctrl_s, hit_status_s, hit_result_s;
   logic       start_s, complete_s, abort_s;
   logic       tmo_start_s, tmo_active_s, tmo_expired_s;

   assign addr_ext_s   = 8'(ADDR);
   assign wr_s         = ENABLE & WRITE;
   assign rd_s         = ENABLE & ~WRITE;
   assign busy_s       = (state_q != ST_IDLE);
   assign hit_op_s     = (addr_ext_s < 8'(NUM_OPS));
   assign hit_ctrl_s   = (addr_ext_s == IDX.ctrl);
   assign hit_status_s = (addr_ext_s == IDX.status);
   assign hit_result_s = (addr_ext_s == IDX.result);
   assign start_s      = wr_s & hit_ctrl_s & ~busy_s & WDATA[CTRL_START_BIT];
   assign tmo_active_s = (state_q == ST_WAIT);

   fpu_csr_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (CLK),
      .rst_i     (RST),
      .start_i   (tmo_start_s),
      .active_i  (tmo_active_s),
      .expired_o (tmo_expired_s)
   );

   // Handshake FSM next state; VALID wins over an expiring watchdog.
   always_comb begin
      state_d     = state_q;
      complete_s  = 1'b0;
      abort_s     = 1'b0;
      tmo_start_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (FPU_ACK && FPU_VALID) begin
               complete_s = 1'b1;
               state_d    = ST_IDLE;
            end else if (FPU_ACK) begin
               tmo_start_s = 1'b1;
               state_d     = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (FPU_VALID) begin
               complete_s = 1'b1;
               state_d    = ST_IDLE;
            end else if (tmo_expired_s) begin
               abort_s = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register-file updates; completion is applied last so its set beats a W1C.
   always_comb begin
      op_d     = op_q;
      opsel_d  = opsel_q;
      ie_d     = ie_q;
      done_d   = done_q;
      err_d    = err_q;
      to_d     = to_q;
      flags_d  = flags_q;
      result_d = result_q;
      if (wr_s && (hit_op_s || hit_ctrl_s)) begin
         if (busy_s) begin
            err_d = 1'b1;
         end else if (hit_ctrl_s) begin
            opsel_d = WDATA[OPSEL_W-1:0];
            ie_d    = WDATA[CTRL_IE_BIT];
            if (WDATA[CTRL_START_BIT]) begin
               done_d  = 1'b0;
               to_d    = 1'b0;
               flags_d = {FLAGS_W{1'b0}};
            end else begin
               done_d = done_q;
            end
         end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (addr_ext_s == 8'(i)) begin
                  op_d[i*DATA_WIDTH +: DATA_WIDTH] = WDATA;
               end else begin
                  op_d[i*DATA_WIDTH +: DATA_WIDTH] = op_q[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end else if (wr_s && hit_status_s) begin
         done_d = done_q & ~WDATA[STAT_DONE_BIT];
         err_d  = err_q  & ~WDATA[STAT_ERR_BIT];
         to_d   = to_q   & ~WDATA[STAT_TO_BIT];
      end else begin
         err_d = err_q;
      end
      if (complete_s) begin
         result_d = FPU_RESULT;
         flags_d  = FPU_FLAGS;
         done_d   = 1'b1;
      end else if (abort_s) begin
         to_d   = 1'b1;
         done_d = 1'b1;
      end else begin
         result_d = result_d;
      end
   end

   // Read mux over the pre-edge register values.
   always_comb begin
      rd_mux_s = {DATA_WIDTH{1'b0}};
      if (hit_op_s) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (addr_ext_s == 8'(i)) begin
               rd_mux_s = op_q[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               rd_mux_s = rd_mux_s;
            end
         end
      end else if (hit_ctrl_s) begin
         rd_mux_s[OPSEL_W-1:0]  = opsel_q;
         rd_mux_s[CTRL_IE_BIT]  = ie_q;
      end else if (hit_status_s) begin
         rd_mux_s[STAT_BUSY_BIT] = busy_s;
         rd_mux_s[STAT_DONE_BIT] = done_q;
         rd_mux_s[STAT_ERR_BIT]  = err_q;
         rd_mux_s[STAT_TO_BIT]   = to_q;
         rd_mux_s[STAT_FLAGS_LSB +: FLAGS_W] = flags_q;
      end else if (hit_result_s) begin
         rd_mux_s = result_q;
      end else begin
         rd_mux_s = {DATA_WIDTH{1'b0}};
      end
   end

   // RDATA holds its value between reads.
   always_comb begin
      if (rd_s) begin
         rdata_d = rd_mux_s;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State and register storage with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         op_q     <= {(NUM_OPS*DATA_WIDTH){1'b0}};
         opsel_q  <= {OPSEL_W{1'b0}};
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         flags_q  <= {FLAGS_W{1'b0}};
         result_q <= {DATA_WIDTH{1'b0}};
         rdata_q  <= {DATA_WIDTH{1'b0}};
         req_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opsel_q  <= opsel_d;
         ie_q     <= ie_d;
         done_q   <= done_d;
         err_q    <= err_d;
         to_q     <= to_d;
         flags_q  <= flags_d;
         result_q <= result_d;
         rdata_q  <= rdata_d;
         req_q    <= (state_d == ST_REQ);
         irq_q    <= done_d & ie_d;
      end
   end

   assign RDATA     = rdata_q;
   assign OP_BUS    = op_q;
   assign OP_SELECT = opsel_q;
   assign FPU_REQ   = req_q;
   assign IRQ       = irq_q;

endmodule
